pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 32 +++
 rtl/pc_sequencer_next_mux.sv | 89 ++++++++
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared processor definitions used by the fetch PC sequencer:
//   pc_state_t   - sequencer FSM states (BOOT, RUN, PEND)
//   redir_src_t  - redirect source, encoded so that a larger value means a
//                  higher priority (exception > jump > branch > none)
//   PC_STEP      - sequential fetch increment
//   align_word() - clears the two low address bits of a target
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_t;

  // Numeric order is the redirect priority; comparisons rely on it.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_EXC    = 2'd3
  } redir_src_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Purely combinational next-PC selection for pc_sequencer.
// Priority: live exception, live jump, live branch, pending redirect, PC+4.
// A live redirect only beats a pending one when its priority is equal or
// higher, so a late lower-priority pulse cannot displace a pending target.
//
// Configuration macro PC_MISALIGN_TRAP_EN:
//   defined   - a jump/branch target with bits[1:0]!=0 becomes EXC_VECTOR and
//               is flagged as misaligned
//   undefined - target bits[1:0] are cleared, nothing is flagged
//
// Ports:
//   i_exception, i_jump, i_jump_target, i_branch_taken, i_branch_target
//                                  - live redirect requests this cycle
//   i_pend_valid, i_pend_src, i_pend_target, i_pend_mis
//                                  - captured (pending) redirect
//   i_pc_plus4                     - sequential fallback address
//   o_next_pc, o_next_mis          - selected next PC and its misalign flag
//   o_live_src, o_live_target, o_live_mis
//                                  - resolved live redirect, for capture
// -----------------------------------------------------------------------------
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        i_exception,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_pend_valid,
  input  redir_src_t  i_pend_src,
  input  logic [31:0] i_pend_target,
  input  logic        i_pend_mis,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic        o_next_mis,
  output redir_src_t  o_live_src,
  output logic [31:0] o_live_target,
  output logic        o_live_mis
);

  logic [31:0] w_raw;

  // Resolve the highest-priority live redirect and its effective target.
  always_comb begin
    o_live_src    = SRC_NONE;
    o_live_target = 32'h0000_0000;
    o_live_mis    = 1'b0;
    w_raw         = 32'h0000_0000;
    if (i_exception) begin
      o_live_src    = SRC_EXC;
      o_live_target = EXC_VECTOR;
    end else if (i_jump) begin
      o_live_src = SRC_JUMP;
      w_raw      = i_jump_target;
    end else if (i_branch_taken) begin
      o_live_src = SRC_BRANCH;
      w_raw      = i_branch_target;
    end
    if ((o_live_src == SRC_JUMP) || (o_live_src == SRC_BRANCH)) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (w_raw[1:0] != 2'b00) begin
        o_live_target = EXC_VECTOR;
        o_live_mis    = 1'b1;
      end else begin
        o_live_target = w_raw;
      end
`else
      o_live_target = align_word(w_raw);
`endif
    end
  end

  always_comb begin
    o_next_pc  = i_pc_plus4;
    o_next_mis = 1'b0;
    if ((o_live_src != SRC_NONE) && (!i_pend_valid || (o_live_src >= i_pend_src))) begin
      o_next_pc  = o_live_target;
      o_next_mis = o_live_mis;
    end else if (i_pend_valid) begin
      o_next_pc  = i_pend_target;
      o_next_mis = i_pend_mis;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch program-counter sequencer: PC register, BOOT/RUN/PEND FSM and the
// pending-redirect register. Next-PC priority selection lives in pc_next_mux.
// Redirect pulses that arrive while the PC cannot advance (imem not ready or
// stall) are held in the pending register and applied on the next advance.
//
// Configuration macro PC_MISALIGN_TRAP_EN:
//   defined   - misaligned jump/branch targets redirect to EXC_VECTOR and
//               misalign_trap pulses for one cycle alongside that pc_out
//   undefined - target bits[1:0] are cleared and misalign_trap is tied low
//
// Ports:
//   clk            - sole clock, rising edge
//   reset          - asynchronous active-high reset
//   stall          - hazard freeze, PC holds
//   imem_ready     - instruction memory accepts pc_out this cycle
//   branch_taken / branch_target - branch redirect pulse and address
//   jump / jump_target           - jump redirect pulse and address
//   exception      - redirect pulse to EXC_VECTOR
//   pc_out         - registered fetch address
//   pc_plus4       - pc_out + 4 (wraps modulo 2^32)
//   pc_valid       - pc_out is a valid fetch request (low in BOOT)
//   misalign_trap  - one-cycle pulse on a misaligned redirect target
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        misalign_trap
);

  pc_state_t   r_state;
  pc_state_t   w_state_nxt;
  logic [31:0] r_pc;
  logic        r_pend_valid;
  redir_src_t  r_pend_src;
  logic [31:0] r_pend_target;
  logic        r_pend_mis;

  logic        w_go;
  logic        w_load_pc;
  logic        w_capture;
  logic        w_clear_pend;
  logic [31:0] w_next_pc;
  logic        w_next_mis;
  redir_src_t  w_live_src;
  logic [31:0] w_live_target;
  logic        w_live_mis;

  assign w_go     = imem_ready & ~stall;
  assign pc_out   = r_pc;
  assign pc_plus4 = r_pc + PC_STEP;
  assign pc_valid = (r_state != ST_BOOT);

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_mux (
    .i_exception     (exception),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_pend_valid    (r_pend_valid),
    .i_pend_src      (r_pend_src),
    .i_pend_target   (r_pend_target),
    .i_pend_mis      (r_pend_mis),
    .i_pc_plus4      (pc_plus4),
    .o_next_pc       (w_next_pc),
    .o_next_mis      (w_next_mis),
    .o_live_src      (w_live_src),
    .o_live_target   (w_live_target),
    .o_live_mis      (w_live_mis)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the PC-load / pending-capture strobes. In PEND a live
  // redirect only overwrites the pending one when its priority is not lower.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_pc    = 1'b0;
    w_capture    = 1'b0;
    w_clear_pend = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_go) begin
          w_load_pc = 1'b1;
        end else if (w_live_src != SRC_NONE) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_go) begin
          w_load_pc    = 1'b1;
          w_clear_pend = 1'b1;
          w_state_nxt  = ST_RUN;
        end else if ((w_live_src != SRC_NONE) && (w_live_src >= r_pend_src)) begin
          w_capture = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_VECTOR;
    end else if (w_load_pc) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_src    <= SRC_NONE;
      r_pend_target <= 32'h0000_0000;
      r_pend_mis    <= 1'b0;
    end else if (w_clear_pend) begin
      r_pend_valid  <= 1'b0;
      r_pend_src    <= SRC_NONE;
      r_pend_target <= 32'h0000_0000;
      r_pend_mis    <= 1'b0;
    end else if (w_capture) begin
      r_pend_valid  <= 1'b1;
      r_pend_src    <= w_live_src;
      r_pend_target <= w_live_target;
      r_pend_mis    <= w_live_mis;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_trap;

  // Pulses in the same cycle pc_out shows the exception vector it caused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_load_pc & w_next_mis;
    end
  end

  assign misalign_trap = r_trap;
`else
  logic w_unused_mis;

  // Misalign flags are always zero in this build.
  assign w_unused_mis  = w_next_mis;
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Each driven cycle pushes the expected
// post-edge outputs onto a scoreboard queue; after the edge the entry is
// popped and compared against the DUT. Misalign expectations follow the
// PC_MISALIGN_TRAP_EN macro.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        misalign_trap;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic        trap;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_PC   = 32'h0000_0180;
  localparam logic        MIS_TRAP = 1'b1;
`else
  localparam logic [31:0] MIS_PC   = 32'h0000_0400;
  localparam logic        MIS_TRAP = 1'b0;
`endif

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .misalign_trap (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic cyc(input logic rdy, input logic stl,
                     input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt,
                     input logic ex,
                     input logic [31:0] e_pc, input logic e_trap);
    exp_t e;
    imem_ready    = rdy;
    stall         = stl;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    exception     = ex;
    e.pc   = e_pc;
    e.vld  = 1'b1;
    e.trap = e_trap;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    jump         = 1'b0;
    exception    = 1'b0;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("pc_out", pc_out, e.pc);
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, e.vld});
      chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, e.trap});
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
    end
  endtask

  task automatic adv(input logic [31:0] e_pc);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, e_pc, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    imem_ready    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    exception     = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pc_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    imem_ready = 1'b1;
    chk("boot_pc_valid", {31'b0, pc_valid}, 32'h0);
    chk("boot_pc_out", pc_out, 32'h0);

    // Sequential fetch out of BOOT
    adv(32'h0000_0000);
    adv(32'h0000_0004);
    adv(32'h0000_0008);
    adv(32'h0000_000C);
    adv(32'h0000_0010);

    // Jump beats a coincident branch
    cyc(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h400, 1'b0);

    // Stall holds, then resumes
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h400, 1'b0);
    adv(32'h0000_0404);

    // Branch while imem not ready is pended, applied two cycles later
    cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h404, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h404, 1'b0);
    adv(32'h0000_0080);
    adv(32'h0000_0084);

    // Exception overwrites a pending branch
    cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h84, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h84, 1'b0);
    adv(32'h0000_0180);
    adv(32'h0000_0184);

    // Lower-priority branch does not overwrite a pending jump
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h184, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h184, 1'b0);
    adv(32'h0000_0300);

    // Higher-priority live jump beats a pending branch on the releasing edge
    cyc(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 32'h300, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h700, 1'b0);
    adv(32'h0000_0704);

    // Branch during stall is pended
    cyc(1'b1, 1'b1, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h704, 1'b0);
    adv(32'h0000_0900);

    // Misaligned jump target
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h402, 1'b0, MIS_PC, MIS_TRAP);
    adv(MIS_PC + 32'd4);

    // Wrap of the address space
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0);
    adv(32'h0000_0000);
    adv(32'h0000_0004);

    // Reset asserted mid-PEND, away from any clock edge
    cyc(1'b0, 1'b0, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 32'h4, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pc_out", pc_out, 32'h0);
    chk("async_rst_pc_valid", {31'b0, pc_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    imem_ready = 1'b1;
    chk("reboot_pc_valid", {31'b0, pc_valid}, 32'h0);
    adv(32'h0000_0000);
    adv(32'h0000_0004);
    adv(32'h0000_0008);

    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
